// File: rtl/tracker_frame_tx_pkg.sv
// Shared definitions for tracker-side serial framing blocks.
// Provides the default sync byte, frame geometry, FSM state encoding and a
// helper that maps (sync, word, byte index) to the byte on the wire.
package tracker_frame_tx_pkg;

    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
    localparam int unsigned FRAME_LEN    = 6;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned IDX_W        = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWaitAck,
        StWaitDone
    } state_e;

    // Frame layout: sync, four data bytes MSB first, XOR checksum of the data bytes.
    function automatic logic [7:0] frame_byte(input logic [7:0]        sync,
                                              input logic [WORD_W-1:0] word,
                                              input logic [IDX_W-1:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = sync;
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            3'd5:    b = word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tracker_frame_tx_if.sv
// Handshake bundle between the frame transmitter and its environment.
//   in_valid/in_data/in_ready : measurement word input, accepted on valid & ready
//   tx_start/tx_data          : one-cycle byte request to the UART emitter
//   uart_ready                : emitter idle (1) / busy (0)
//   busy/overflow             : status (frame in progress / sticky drop flag)
// slave = transmitter side, master = producer + emitter side.
interface tracker_frame_tx_if;
    import tracker_frame_tx_pkg::*;

    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              uart_ready;
    logic              busy;
    logic              overflow;

    modport slave (
        input  in_valid, in_data, uart_ready,
        output in_ready, tx_start, tx_data, busy, overflow
    );

    modport master (
        output in_valid, in_data, uart_ready,
        input  in_ready, tx_start, tx_data, busy, overflow
    );

endinterface

// File: rtl/frame_fifo.sv
// Word FIFO for the frame transmitter.
//   clk, rst        : clock, asynchronous active-high reset
//   push_i, wdata_i : write request and data (ignored while full)
//   pop_i, rdata_o  : read request and head word (rdata_o valid while !empty_o)
//   full_o, empty_o : occupancy flags, derived from registered pointers only
// Pointers carry one extra bit so full and empty are distinguishable.
module frame_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            // Full is judged on registered state: a same-cycle pop does not make room.
            if (push_i && !full_o) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/tracker_frame_tx.sv
// Tracker frame transmitter: buffers 32-bit measurement words and sends each
// as a 6-byte frame (sync, 4 data bytes MSB first, XOR checksum) to a UART
// emitter, one byte per tx_start pulse with a ready/busy handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tracker_frame_tx_if.slave (word input, byte output, status)
// Parameters: DEPTH words buffered (power of 2, 2..16), SYNC frame sync byte.
module tracker_frame_tx
    import tracker_frame_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter logic [7:0]  SYNC  = SYNC_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    tracker_frame_tx_if.slave bus
);

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;

    state_e            state_q;
    logic [WORD_W-1:0] frame_q;
    logic [IDX_W-1:0]  idx_q;
    logic              tx_start_q;
    logic [7:0]        tx_data_q;
    logic              overflow_q;

    assign fifo_push = bus.in_valid & ~fifo_full;
    assign fifo_pop  = (state_q == StLoad) & ~fifo_empty;

    frame_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (bus.in_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (bus.in_valid && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    // The frame register is written only in StLoad, so pushes during a frame
    // never disturb the bytes being sent. tx_data is written only when a byte
    // is started, so it stays put through the emitter handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            frame_q    <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    frame_q <= fifo_rdata;
                    idx_q   <= '0;
                    state_q <= StSend;
                end
                StSend: begin
                    if (bus.uart_ready) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= frame_byte(SYNC, frame_q, idx_q);
                        state_q    <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (!bus.uart_ready) begin
                        state_q <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (bus.uart_ready) begin
                        if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= StSend;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready = ~fifo_full;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = (state_q != StIdle) | ~fifo_empty;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_tracker_frame_tx.sv
// Scoreboard bench for tracker_frame_tx: accepted words push their expected
// frame bytes into a queue; a monitor (which also models the UART emitter)
// pops and compares on every tx_start.
module tb_tracker_frame_tx;

    logic clk;
    logic rst;

    tracker_frame_tx_if bus ();

    tracker_frame_tx #(
        .DEPTH (4),
        .SYNC  (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         total;
    int         bad;
    logic [7:0] sb[$];
    logic [7:0] byte_log[$];
    int         pulses;
    logic       hold;
    logic       rand_em;
    int         ack_delay;
    int         busy_len;
    int         em_t;
    logic       em_active;
    logic       exp_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame = sync, bytes MSB first, XOR of the four bytes.
    function automatic void expect_frame(input logic [31:0] w);
        logic [7:0] b [4];
        logic [7:0] cs;
        b[0] = w[31:24];
        b[1] = w[23:16];
        b[2] = w[15:8];
        b[3] = w[7:0];
        cs   = 8'h00;
        sb.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(b[i]);
            cs = cs ^ b[i];
        end
        sb.push_back(cs);
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w, output logic acc);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        acc          = bus.in_ready;
        if (acc) expect_frame(w);
        else exp_ovf = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < max) begin
            cycles(1);
            n++;
        end
        chk(name, 32'((sb.size() == 0) && !bus.busy), 32'd1);
    endtask

    task automatic chk_log(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, 32'(byte_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < byte_log.size(); i++) begin
            chk(name, 32'(byte_log[i]), 32'(exp[i]));
        end
    endtask

    // Monitor + emitter model. Emitter keeps ready high for ack_delay cycles
    // after a start, low for busy_len cycles, then high again.
    initial begin
        logic       prev_start;
        logic       await_ack;
        logic [7:0] held;
        logic [7:0] exp_b;
        prev_start = 1'b0;
        await_ack  = 1'b0;
        held       = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_start     = 1'b0;
                await_ack      = 1'b0;
                em_active      = 1'b0;
                bus.uart_ready = !hold;
                continue;
            end
            if (await_ack) begin
                chk("tx_data_hold", 32'(bus.tx_data), 32'(held));
                if (!bus.uart_ready) await_ack = 1'b0;
            end
            if (bus.tx_start) begin
                pulses++;
                byte_log.push_back(bus.tx_data);
                chk("tx_start_single", 32'(prev_start), 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx_start: got byte %h want no start at %0t",
                             bus.tx_data, $time);
                end else begin
                    exp_b = sb.pop_front();
                    chk("tx_byte", 32'(bus.tx_data), 32'(exp_b));
                end
                held      = bus.tx_data;
                await_ack = 1'b1;
                em_active = 1'b1;
                em_t      = 0;
                if (rand_em) begin
                    ack_delay = int'($urandom_range(0, 3));
                    busy_len  = int'($urandom_range(1, 6));
                end
            end else if (em_active) begin
                em_t++;
                if (em_t >= ack_delay + busy_len) em_active = 1'b0;
            end
            prev_start     = bus.tx_start;
            bus.uart_ready = hold ? 1'b0 : !(em_active && em_t >= ack_delay);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        int         base;
        int         n;
        logic [7:0] exp_q[$];

        total     = 0;
        bad       = 0;
        pulses    = 0;
        hold      = 1'b0;
        rand_em   = 1'b0;
        ack_delay = 3;
        busy_len  = 100;
        em_t      = 0;
        em_active = 1'b0;
        exp_ovf   = 1'b0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.uart_ready = 1'b1;
        cycles(3);

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        cycles(2);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Single word, slow emitter; latency from push edge N to start at N+3.
        byte_log.delete();
        base         = pulses;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        chk("lat_in_ready", 32'(bus.in_ready), 32'd1);
        expect_frame(32'h1234_5678);
        cycles(1);
        bus.in_valid = 1'b0;
        chk("lat_n0", 32'(bus.tx_start), 32'd0);
        cycles(1);
        chk("lat_n1", 32'(bus.tx_start), 32'd0);
        cycles(1);
        chk("lat_n2", 32'(bus.tx_start), 32'd0);
        cycles(1);
        chk("lat_n3_start", 32'(bus.tx_start), 32'd1);
        chk("lat_n3_sync", 32'(bus.tx_data), 32'hA5);
        cycles(1);
        chk("lat_n4_start_low", 32'(bus.tx_start), 32'd0);
        wait_drain("drain_12345678", 1500);
        chk("pulses_12345678", 32'(pulses - base), 32'd6);
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        chk_log("log_12345678", exp_q);

        // All-zero and all-one words back to back.
        ack_delay = 1;
        busy_len  = 2;
        byte_log.delete();
        push_word(32'h0000_0000, acc);
        chk("acc_zero", 32'(acc), 32'd1);
        push_word(32'hFFFF_FFFF, acc);
        chk("acc_ones", 32'(acc), 32'd1);
        wait_drain("drain_00_ff", 500);
        exp_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        chk_log("log_00_ff", exp_q);

        // Emitter stalled: one frame held in SEND, then fill the FIFO.
        hold = 1'b1;
        cycles(2);
        push_word(32'hA0A0_0001, acc);
        cycles(4);
        chk("stall_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("ovf_before_drop", 32'(bus.overflow), 32'd0);
            push_word(32'h5000_0000 + 32'(i * 32'h0101_0101), acc);
            chk("fill_accept", 32'(acc), 32'(i < 4));
        end
        chk("ovf_after_drop", 32'(bus.overflow), 32'd1);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);

        // Release and keep offering junk while full, including the pop cycle.
        hold = 1'b0;
        n    = 0;
        while (bus.in_ready == 1'b0 && n < 3000) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hDEAD_0000 + 32'(n);
            cycles(1);
            n++;
        end
        bus.in_valid = 1'b0;
        chk("junk_bounded", 32'(n < 3000), 32'd1);
        wait_drain("drain_full", 3000);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset during byte 3 of a frame.
        ack_delay = 3;
        busy_len  = 20;
        base      = pulses;
        push_word(32'hCAFE_BABE, acc);
        n = 0;
        while (pulses < base + 4 && n < 1000) begin
            cycles(1);
            n++;
        end
        chk("reached_byte3", 32'(pulses - base), 32'd4);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        exp_ovf = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(40);
        chk("no_resume", 32'(pulses - base), 32'd4);
        chk("no_resume_busy", 32'(bus.busy), 32'd0);
        push_word(32'h0BAD_F00D, acc);
        wait_drain("drain_after_rst", 1000);
        chk("frame_after_rst", 32'(pulses - base), 32'd10);

        // Random traffic with a randomly paced emitter.
        rand_em = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) push_word($urandom, acc);
            else cycles(1);
        end
        wait_drain("drain_random", 5000);
        chk("ovf_random", 32'(bus.overflow), 32'(exp_ovf));
        rand_em = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
